data_mem_burst: RTL and testbench
=================================

# data_mem_burst

Parametrised synchronous data memory for the CPU load/store path. It replaces single-cycle combinational access with a clocked, registered-read array driven by a small burst sequencer. One request moves 1..MAX_BURST consecutive words from a base address, which serves both LDR/STR (count 1) and LDM/STM-style multi-word transfers. Write data arrives on a valid/ready stream with per-byte strobes; read data leaves on a valid-only stream tagged with its word index.

## Interface
- DATA_W, 32, word width in bits; multiple of 8
- ADDR_W, 8, word-address width; depth = 2**ADDR_W words
- MAX_BURST, 16, largest legal word count per request
- CNT_W, $clog2(MAX_BURST+1), width of count and index fields
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  1  request strobe; sampled only in IDLE
- we  in  1  1 = store burst, 0 = load burst; captured with req
- base_addr  in  ADDR_W  first word address; captured with req
- count  in  CNT_W  number of words; captured with req
- wdata  in  DATA_W  store data word
- wstrb  in  DATA_W/8  byte enables for wdata; bit k covers byte k
- wvalid  in  1  wdata/wstrb valid
- wready  out  1  block accepts a store word this cycle
- rdata  out  DATA_W  registered load data
- rindex  out  CNT_W  burst index (0-based) of rdata
- rvalid  out  1  rdata/rindex valid for this cycle; no backpressure
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse at burst completion
- err  out  1  one-cycle pulse with done for an illegal count

## Operation
- FSM states: IDLE, LOAD, STORE. An internal index idx is CNT_W bits. Captured regs are base_r, cnt_r, we_r.
- IDLE with req=1:
  - count==0 or count>MAX_BURST: stay IDLE, pulse done=1 and err=1 next cycle; no memory access.
  - otherwise: capture the fields, set idx=0, go to LOAD or STORE per we.
- Word address = (base_r + idx) mod 2**ADDR_W. The address wraps silently past the top word; this is not an error.
- LOAD: every cycle, rdata<=mem[addr], rindex<=idx, rvalid<=1, idx++. The edge that reads idx==cnt_r-1 also sets done<=1 and the state to IDLE.
- STORE: wready=1 (combinational from state). On each edge with wvalid=1:
  - each byte k with wstrb[k]=1 is written to mem[addr]; bytes with strobe 0 are unchanged;
  - idx increments.
  - When the last word is written, done<=1 and the state goes to IDLE.
  - wvalid=0 stalls the burst indefinitely with no timeout.
- req while busy is ignored; it is not queued.
- we, base_addr and count are don't-care outside the request cycle.
- The array is never reset. Its contents survive rst_n, and an unwritten word reads X in simulation.

## Timing
- Reset values: rdata=0, rindex=0, rvalid=0, done=0, err=0, busy=0, wready=0, state=IDLE, idx=0.
- Reset mid-burst: the FSM returns to IDLE immediately. No done pulse. Store words already written remain; later words are not written.
- Load, N words, req sampled at edge E0:
  - rvalid is high after edges E1..EN with rindex 0..N-1.
  - done is high after EN, coincident with the last rvalid.
  - busy is high from after E0 until EN; a new req is accepted at E(N+1).
- Store: wready is high after E0. The burst completes on the edge of the N-th accepted beat; done pulses in the following cycle with wready=0.
- done is a single-cycle pulse. rvalid is never high outside LOAD-produced cycles.
- Back-to-back: req held high during the done cycle is accepted at the next edge, giving zero idle cycles.

## Structure
- Shared package (cpu_mem_pkg): state enum (IDLE, LOAD, STORE) and default widths. CPU top-level instances override the DATA_W/ADDR_W/MAX_BURST values.
- One sub-module, mem_array_bw: a byte-writable RAM.
  - One write port with byte strobes.
  - One registered read port, 1-cycle latency.
  - Suitable for block-RAM inference.
- The sequencer (FSM, idx, done/err generation) lives in data_mem_burst.

## Test plan
- Reset and single store/load: store base=0x10, count=1, wdata=0xDEADBEEF, wstrb=0xF → done after 1 beat. Then load base=0x10, count=1 → rvalid one cycle after the LOAD cycle with rdata=0xDEADBEEF, rindex=0, done coincident.
- Burst with stalls and wrap: store base=0xFE, count=4, data 1..4, with wvalid low for 2 cycles mid-burst → words land at 0xFE, 0xFF, 0x00, 0x01. Load back → rdata 1,2,3,4 on 4 consecutive cycles, rindex 0..3.
- Byte strobes: preload 0x11223344, store 0xAABBCCDD with wstrb=0b0101 → readback 0x11BB33DD.
- Illegal counts: count=0 and count=17 (MAX_BURST=16) → done=1 and err=1 one cycle later, busy stays 0, memory unchanged.
- Busy/overlap: req asserted during a LOAD burst → ignored. req held through the done cycle → the next burst starts with zero gap.
- Reset mid-store: rst_n low after 2 of 5 beats → all outputs return to reset values asynchronously, no done pulse, the first 2 words persist, words 3–5 are unchanged.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and default geometry for the CPU data-memory path.
package cpu_mem_pkg;

   localparam int unsigned DEF_DATA_W    = 32;
   localparam int unsigned DEF_ADDR_W    = 8;
   localparam int unsigned DEF_MAX_BURST = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      STORE = 2'd2
   } state_t;

endpackage

// File: rtl/mem_array_bw.sv
// Byte-writable single-clock RAM: one strobed write port, one registered read port.
module mem_array_bw #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [DATA_W/8-1:0]   wr_strb,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_W-1:0]     rd_data
);

   localparam int unsigned DEPTH  = 2**ADDR_W;
   localparam int unsigned STRB_W = DATA_W/8;

   logic [DATA_W-1:0] mem [DEPTH];

   // Array contents are intentionally unreset so they survive rst_n.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int unsigned k = 0; k < STRB_W; k++) begin
            if (wr_strb[k]) mem[wr_addr][k*8 +: 8] <= wr_data[k*8 +: 8];
         end
      end
   end

   // Read register holds its value between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/data_mem_burst.sv
// Burst sequencer over a byte-writable RAM: moves 1..MAX_BURST consecutive
// words per request, stores from a valid/ready stream, loads to a valid-only stream.
module data_mem_burst
   import cpu_mem_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned MAX_BURST = DEF_MAX_BURST,
   parameter int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [CNT_W-1:0]      count,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wstrb,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [DATA_W-1:0]     rdata,
   output logic [CNT_W-1:0]      rindex,
   output logic                  rvalid,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   state_t            state, state_nx;
   logic [CNT_W-1:0]  idx, idx_nx;
   logic [CNT_W-1:0]  cnt_r, cnt_nx;
   logic [ADDR_W-1:0] base_r, base_nx;
   logic [CNT_W-1:0]  rindex_nx;
   logic              rvalid_nx, done_nx, err_nx;
   logic              mem_we, mem_re;
   logic [ADDR_W-1:0] mem_addr;
   logic              last_c, bad_cnt_c;

   assign mem_addr  = base_r + ADDR_W'(idx);
   assign last_c    = (idx == cnt_r - CNT_W'(1));
   assign bad_cnt_c = (count == '0) || (count > CNT_W'(MAX_BURST));
   assign wready    = (state == STORE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         idx    <= '0;
         cnt_r  <= '0;
         base_r <= '0;
         rindex <= '0;
         rvalid <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_nx;
         idx    <= idx_nx;
         cnt_r  <= cnt_nx;
         base_r <= base_nx;
         rindex <= rindex_nx;
         rvalid <= rvalid_nx;
         done   <= done_nx;
         err    <= err_nx;
         busy   <= (state_nx != IDLE);
      end
   end

   // Next-state, burst bookkeeping and memory port control.
   always_comb begin
      state_nx  = state;
      idx_nx    = idx;
      cnt_nx    = cnt_r;
      base_nx   = base_r;
      rindex_nx = rindex;
      rvalid_nx = 1'b0;
      done_nx   = 1'b0;
      err_nx    = 1'b0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (bad_cnt_c) begin
                  done_nx = 1'b1;
                  err_nx  = 1'b1;
               end else begin
                  base_nx  = base_addr;
                  cnt_nx   = count;
                  idx_nx   = '0;
                  state_nx = we ? STORE : LOAD;
               end
            end
         end
         LOAD: begin
            mem_re    = 1'b1;
            rvalid_nx = 1'b1;
            rindex_nx = idx;
            idx_nx    = idx + CNT_W'(1);
            if (last_c) begin
               done_nx  = 1'b1;
               state_nx = IDLE;
            end
         end
         STORE: begin
            if (wvalid) begin
               mem_we = 1'b1;
               idx_nx = idx + CNT_W'(1);
               if (last_c) begin
                  done_nx  = 1'b1;
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   mem_array_bw #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (mem_we),
      .wr_addr (mem_addr),
      .wr_data (wdata),
      .wr_strb (wstrb),
      .rd_en   (mem_re),
      .rd_addr (mem_addr),
      .rd_data (rdata)
   );

endmodule

// File: tb/tb_data_mem_burst.sv
// Randomized self-checking bench for data_mem_burst against a word-array memory model.
module tb_data_mem_burst;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned ADDR_W    = 8;
   localparam int unsigned MAX_BURST = 16;
   localparam int unsigned CNT_W     = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req, we, wvalid;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] wdata;
   logic [3:0]        wstrb;
   logic              wready, rvalid, busy, done, err;
   logic [DATA_W-1:0] rdata;
   logic [CNT_W-1:0]  rindex;

   logic [DATA_W-1:0] model [256];
   logic [DATA_W-1:0] beat_data [16];
   logic [3:0]        beat_strb [16];
   int                n_vec = 0;
   int                n_err = 0;

   always #5 clk = ~clk;

   data_mem_burst #(
      .DATA_W (DATA_W), .ADDR_W (ADDR_W), .MAX_BURST (MAX_BURST), .CNT_W (CNT_W)
   ) dut (
      .clk (clk), .rst_n (rst_n), .req (req), .we (we), .base_addr (base_addr),
      .count (count), .wdata (wdata), .wstrb (wstrb), .wvalid (wvalid),
      .wready (wready), .rdata (rdata), .rindex (rindex), .rvalid (rvalid),
      .busy (busy), .done (done), .err (err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one request for a single edge.
   task automatic start_req(input bit w, input logic [7:0] b, input logic [4:0] c);
      req = 1'b1; we = w; base_addr = b; count = c;
      step();
      req = 1'b0;
   endtask

   task automatic run_load(input logic [7:0] b, input int n);
      logic [7:0] a;
      n_vec++;
      if ({busy, wready} !== 2'b10) begin
         n_err++; $display("FAIL load_entry base=%h busy/wready=%b expected 10", b, {busy, wready});
      end
      for (int i = 0; i < n; i++) begin
         step();
         a = b + 8'(i);
         n_vec++;
         if ({rvalid, rindex, done, err} !== {1'b1, 5'(i), (i == n-1), 1'b0}) begin
            n_err++;
            $display("FAIL load_ctl base=%h i=%0d rvalid=%b rindex=%0d done=%b err=%b expected rindex=%0d done=%b",
                     b, i, rvalid, rindex, done, err, i, (i == n-1));
         end
         n_vec++;
         if (rdata !== model[a]) begin
            n_err++; $display("FAIL load_data addr=%h got %h expected %h", a, rdata, model[a]);
         end
      end
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL load_busy_end base=%h busy=%b expected 0", b, busy);
      end
   endtask

   // Feeds `beats` of an n-word store, with optional stalls before beats.
   task automatic run_store(input logic [7:0] b, input int n, input int beats,
                            input int stall_at, input int stall_len, input bit rnd);
      logic [7:0] a;
      int s;
      n_vec++;
      if ({busy, wready} !== 2'b11) begin
         n_err++; $display("FAIL store_entry base=%h busy/wready=%b expected 11", b, {busy, wready});
      end
      for (int i = 0; i < beats; i++) begin
         s = (i == stall_at) ? stall_len : 0;
         if (rnd) s += int'($urandom_range(0, 2));
         for (int k = 0; k < s; k++) begin
            wvalid = 1'b0; wdata = $urandom; wstrb = 4'($urandom);
            step();
            n_vec++;
            if ({wready, done, busy} !== 3'b101) begin
               n_err++; $display("FAIL store_stall base=%h i=%0d wready/done/busy=%b expected 101",
                                 b, i, {wready, done, busy});
            end
         end
         wvalid = 1'b1; wdata = beat_data[i]; wstrb = beat_strb[i];
         step();
         a = b + 8'(i);
         for (int k = 0; k < 4; k++)
            if (beat_strb[i][k]) model[a][k*8 +: 8] = beat_data[i][k*8 +: 8];
         wvalid = 1'b0;
         n_vec++;
         if ({wready, done, busy, err} !== {(i != n-1), (i == n-1), (i != n-1), 1'b0}) begin
            n_err++; $display("FAIL store_beat base=%h i=%0d wready/done/busy/err=%b last=%b",
                              b, i, {wready, done, busy, err}, (i == n-1));
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 1'b0; we = 1'b0; base_addr = '0; count = '0;
      wdata = '0; wstrb = '0; wvalid = 1'b0;
      repeat (2) step();
      n_vec++;
      if ({rdata, rindex, rvalid, done, err, busy, wready} !== '0) begin
         n_err++; $display("FAIL reset_values rdata=%h rindex=%0d rvalid=%b done=%b err=%b busy=%b wready=%b expected all 0",
                           rdata, rindex, rvalid, done, err, busy, wready);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_fill();
      for (int blk = 0; blk < 16; blk++) begin
         for (int i = 0; i < 16; i++) begin beat_data[i] = $urandom; beat_strb[i] = 4'hF; end
         start_req(1'b1, 8'(blk * 16), 5'd16);
         run_store(8'(blk * 16), 16, 16, -1, 0, 1'b0);
      end
   endtask

   task automatic test_single();
      beat_data[0] = 32'hDEADBEEF; beat_strb[0] = 4'hF;
      start_req(1'b1, 8'h10, 5'd1);
      run_store(8'h10, 1, 1, -1, 0, 1'b0);
      start_req(1'b0, 8'h10, 5'd1);
      run_load(8'h10, 1);
      n_vec++;
      if (rdata !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL single_word got %h expected deadbeef", rdata);
      end
   endtask

   task automatic test_wrap_stall();
      for (int i = 0; i < 4; i++) begin beat_data[i] = 32'(i + 1); beat_strb[i] = 4'hF; end
      start_req(1'b1, 8'hFE, 5'd4);
      run_store(8'hFE, 4, 4, 2, 2, 1'b0);
      start_req(1'b0, 8'hFE, 5'd4);
      run_load(8'hFE, 4);
      start_req(1'b0, 8'h01, 5'd1);
      run_load(8'h01, 1);
      n_vec++;
      if (rdata !== 32'd4) begin
         n_err++; $display("FAIL wrap_word_0x01 got %h expected 4", rdata);
      end
      start_req(1'b0, 8'hFF, 5'd1);
      run_load(8'hFF, 1);
      n_vec++;
      if (rdata !== 32'd2) begin
         n_err++; $display("FAIL wrap_word_0xff got %h expected 2", rdata);
      end
   endtask

   task automatic test_strobe();
      beat_data[0] = 32'h11223344; beat_strb[0] = 4'hF;
      start_req(1'b1, 8'h20, 5'd1);
      run_store(8'h20, 1, 1, -1, 0, 1'b0);
      beat_data[0] = 32'hAABBCCDD; beat_strb[0] = 4'b0101;
      start_req(1'b1, 8'h20, 5'd1);
      run_store(8'h20, 1, 1, -1, 0, 1'b0);
      start_req(1'b0, 8'h20, 5'd1);
      run_load(8'h20, 1);
      n_vec++;
      if (rdata !== 32'h11BB33DD) begin
         n_err++; $display("FAIL byte_strobe got %h expected 11bb33dd", rdata);
      end
   endtask

   task automatic test_illegal();
      logic [4:0] bad [3];
      bad[0] = 5'd0; bad[1] = 5'd17; bad[2] = 5'd31;
      for (int j = 0; j < 3; j++) begin
         wvalid = 1'b1; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
         start_req(j[0] == 1'b0, 8'h20, bad[j]);
         n_vec++;
         if ({done, err, busy, wready} !== 4'b1100) begin
            n_err++; $display("FAIL illegal_pulse count=%0d done/err/busy/wready=%b expected 1100",
                              bad[j], {done, err, busy, wready});
         end
         step();
         n_vec++;
         if ({done, err, busy, wready} !== 4'b0000) begin
            n_err++; $display("FAIL illegal_after count=%0d done/err/busy/wready=%b expected 0000",
                              bad[j], {done, err, busy, wready});
         end
         wvalid = 1'b0;
      end
      start_req(1'b0, 8'h20, 5'd1);
      run_load(8'h20, 1);
      n_vec++;
      if (rdata !== 32'h11BB33DD) begin
         n_err++; $display("FAIL illegal_mem_untouched got %h expected 11bb33dd", rdata);
      end
   endtask

   task automatic test_overlap();
      start_req(1'b0, 8'h30, 5'd6);
      req = 1'b1; we = 1'b1; base_addr = 8'h50; count = 5'd3;
      run_load(8'h30, 6);
      req = 1'b0;
      step();
      n_vec++;
      if ({busy, wready, rvalid, done} !== 4'b0000) begin
         n_err++; $display("FAIL overlap_ignored busy/wready/rvalid/done=%b expected 0000",
                           {busy, wready, rvalid, done});
      end
   endtask

   task automatic test_back_to_back();
      req = 1'b1; we = 1'b0; base_addr = 8'h70; count = 5'd3;
      step();
      base_addr = 8'h7E; count = 5'd4;
      run_load(8'h70, 3);
      step();
      req = 1'b0;
      run_load(8'h7E, 4);
   endtask

   task automatic test_reset_mid_store();
      for (int i = 0; i < 5; i++) begin
         beat_data[i] = $urandom; beat_strb[i] = 4'hF;
         while (beat_data[i] == model[8'h40 + 8'(i)]) beat_data[i] = $urandom;
      end
      start_req(1'b1, 8'h40, 5'd5);
      run_store(8'h40, 5, 2, -1, 0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({rdata, rindex, rvalid, done, err, busy, wready} !== '0) begin
         n_err++; $display("FAIL async_reset rindex=%0d rvalid=%b done=%b err=%b busy=%b wready=%b rdata=%h expected all 0",
                           rindex, rvalid, done, err, busy, wready, rdata);
      end
      wvalid = 1'b1; wdata = beat_data[2]; wstrb = 4'hF;
      step();
      rst_n = 1'b1;
      wvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         n_vec++;
         if ({done, busy, wready} !== 3'b000) begin
            n_err++; $display("FAIL post_reset_quiet k=%0d done/busy/wready=%b expected 000",
                              k, {done, busy, wready});
         end
      end
      start_req(1'b0, 8'h40, 5'd5);
      run_load(8'h40, 5);
   endtask

   task automatic test_random();
      logic [7:0] b;
      int n;
      for (int t = 0; t < 40; t++) begin
         b = 8'($urandom);
         n = int'($urandom_range(1, MAX_BURST));
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < 16; i++) begin beat_data[i] = $urandom; beat_strb[i] = 4'($urandom); end
            start_req(1'b1, b, 5'(n));
            run_store(b, n, n, -1, 0, 1'b1);
         end else begin
            start_req(1'b0, b, 5'(n));
            run_load(b, n);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_single();
      test_wrap_stall();
      test_strobe();
      test_illegal();
      test_overlap();
      test_back_to_back();
      test_reset_mid_store();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
